// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_pkg
//  Description : Shared constants and types for the 1-to-3 demultiplexer.
//                This covers the select encodings, the default data width and
//                the per-output slot states.
//  Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

  // Default data width of the input word and of each output.
  localparam int DEFAULT_WIDTH = 32;

  // Number of outputs and the width of the optional drain counters.
  localparam int NUM_OUT = 3;
  localparam int CNT_W   = 16;

  // Destination select encodings.
  localparam logic [1:0] SEL_Y0  = 2'b00;
  localparam logic [1:0] SEL_Y1  = 2'b01;
  localparam logic [1:0] SEL_Y2  = 2'b10;
  localparam logic [1:0] SEL_BAD = 2'b11;

  // One-entry output slot occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
//  Module      : demux_slot
//  Description : One-entry output slot with a valid/ready handshake. It holds
//                the registered data word, the EMPTY/FULL state and, when
//                DEMUX_1X3_STATS_EN is defined, a 16-bit wrapping drain counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_slot
  import demux_pkg::*;
#(
  parameter int bitwidth = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [bitwidth-1:0] load_data,
  input  logic                out_ready,
  output logic [bitwidth-1:0] out_data,
  output logic                out_valid,
  output logic                can_load
`ifdef DEMUX_1X3_STATS_EN
  ,
  output logic [CNT_W-1:0]    cnt
`endif
);

  slot_state_t         state_q, state_d;
  logic [bitwidth-1:0] data_q, data_d;
  logic                drain;

  // The consumer takes the held word; a load in the same cycle keeps the slot full.
  always_comb begin
    drain    = (state_q == FULL) && out_ready;
    can_load = (state_q == EMPTY) || out_ready;
    state_d  = state_q;
    data_d   = data_q;
    if (load) begin
      state_d = FULL;
      data_d  = load_data;
    end else if (drain) begin
      state_d = EMPTY;
    end
  end

  // Slot state and data registers; the data word is kept after a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = (state_q == FULL);

`ifdef DEMUX_1X3_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count drains; the counter wraps naturally at 16 bits.
  always_comb begin
    cnt_d = cnt_q;
    if (drain) cnt_d = cnt_q + 1'b1;
  end

  // Drain counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
`endif

endmodule : demux_slot
`default_nettype wire

// File: rtl/demux_1x3.sv
`default_nettype none
// ============================================================================
//  Module      : demux_1x3
//  Description : Handshaked 1-to-3 demultiplexer with registered outputs and
//                one-cycle latency. A word with sel=11 is accepted, discarded
//                and flagged on err for one cycle. When DEMUX_1X3_STATS_EN is
//                defined, per-output 16-bit drain counters (cnt0..cnt2) are
//                added.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_1x3
  import demux_pkg::*;
#(
  parameter int bitwidth = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          sel,
  input  logic [bitwidth-1:0] d,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [bitwidth-1:0] y0,
  output logic [bitwidth-1:0] y1,
  output logic [bitwidth-1:0] y2,
  output logic [2:0]          y_valid,
  input  logic [2:0]          y_ready,
  output logic                err
`ifdef DEMUX_1X3_STATS_EN
  ,
  output logic [CNT_W-1:0]    cnt0,
  output logic [CNT_W-1:0]    cnt1,
  output logic [CNT_W-1:0]    cnt2
`endif
);

  logic [NUM_OUT-1:0]  can_load;
  logic [NUM_OUT-1:0]  load;
  logic [bitwidth-1:0] y_arr [NUM_OUT];
  logic                err_q, err_d;
  logic                accept;
`ifdef DEMUX_1X3_STATS_EN
  logic [CNT_W-1:0]    cnt_arr [NUM_OUT];
`endif

  // Ready follows the selected slot only; an invalid select is always taken.
  always_comb begin
    in_ready = 1'b1;
    case (sel)
      SEL_Y0:  in_ready = can_load[0];
      SEL_Y1:  in_ready = can_load[1];
      SEL_Y2:  in_ready = can_load[2];
      default: in_ready = 1'b1;
    endcase
    accept = in_valid && in_ready;
    err_d  = accept && (sel == SEL_BAD);
  end

  generate
    for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
      assign load[i] = accept && (sel == 2'(i));

      demux_slot #(
        .bitwidth (bitwidth)
      ) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load[i]),
        .load_data (d),
        .out_ready (y_ready[i]),
        .out_data  (y_arr[i]),
        .out_valid (y_valid[i]),
        .can_load  (can_load[i])
`ifdef DEMUX_1X3_STATS_EN
        ,
        .cnt       (cnt_arr[i])
`endif
      );
    end
  endgenerate

  // One-cycle error pulse for a consumed invalid-select word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
  assign y0  = y_arr[0];
  assign y1  = y_arr[1];
  assign y2  = y_arr[2];

`ifdef DEMUX_1X3_STATS_EN
  assign cnt0 = cnt_arr[0];
  assign cnt1 = cnt_arr[1];
  assign cnt2 = cnt_arr[2];
`endif

endmodule : demux_1x3
`default_nettype wire

// File: tb/tb_demux_1x3.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_1x3
//  Description : Self-checking bench for demux_1x3 with directed scenarios and
//                randomized traffic compared against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1x3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  sel = 2'b00;
  logic [31:0] d = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] y0, y1, y2;
  logic [2:0]  y_valid;
  logic [2:0]  y_ready = 3'b000;
  logic        err;
`ifdef DEMUX_1X3_STATS_EN
  logic [15:0] cnt0, cnt1, cnt2;
`endif

  int checks = 0;
  int errors = 0;

  demux_1x3 #(.bitwidth(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sel      (sel),
    .d        (d),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y0       (y0),
    .y1       (y1),
    .y2       (y2),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .err      (err)
`ifdef DEMUX_1X3_STATS_EN
    ,
    .cnt0     (cnt0),
    .cnt1     (cnt1),
    .cnt2     (cnt2)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit          m_full [3];
  logic [31:0] m_data [3];
  int          m_cnt  [3];
  bit          m_err;

  function automatic bit m_ready();
    if (sel == 2'd3) return 1'b1;
    return !m_full[sel] || y_ready[sel];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_full[i] = 0; m_data[i] = '0; m_cnt[i] = 0;
      end
      m_err = 0;
    end else begin
      bit taken;
      taken = in_valid && m_ready();
      m_err = taken && (sel == 2'd3);
      for (int i = 0; i < 3; i++) begin
        bit drained;
        drained = m_full[i] && y_ready[i];
        if (drained) m_cnt[i] = (m_cnt[i] + 1) % 65536;
        if (taken && int'(sel) == i) begin
          m_full[i] = 1; m_data[i] = d;
        end else if (drained) begin
          m_full[i] = 0;
        end
      end
    end
  end

  // Compare process: outputs are stable mid-cycle.
  always @(negedge clk) begin
    chk("in_ready", {63'd0, in_ready}, {63'd0, m_ready()});
    chk("y_valid", {61'd0, y_valid}, {61'd0, m_full[2], m_full[1], m_full[0]});
    chk("y0", {32'd0, y0}, {32'd0, m_data[0]});
    chk("y1", {32'd0, y1}, {32'd0, m_data[1]});
    chk("y2", {32'd0, y2}, {32'd0, m_data[2]});
    chk("err", {63'd0, err}, {63'd0, m_err});
`ifdef DEMUX_1X3_STATS_EN
    chk("cnt0", {48'd0, cnt0}, 64'(m_cnt[0]));
    chk("cnt1", {48'd0, cnt1}, 64'(m_cnt[1]));
    chk("cnt2", {48'd0, cnt2}, 64'(m_cnt[2]));
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_y_valid", {61'd0, y_valid}, 64'd0);
    chk("rst_y0", {32'd0, y0}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    #20 rst_n = 1'b1;
    cyc();

    // Single word to y1
    y_ready = 3'b111; sel = 2'b01; d = 32'hDEADBEEF; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("single_y1", {32'd0, y1}, 64'hDEADBEEF);
    chk("single_valid", {61'd0, y_valid}, 64'b010);
    cyc();
    chk("single_drained", {61'd0, y_valid}, 64'b000);

    // Backpressure on y2
    y_ready = 3'b000; sel = 2'b10; d = 32'h11; in_valid = 1'b1;
    #1 chk("bp_first_ready", {63'd0, in_ready}, 64'd1);
    cyc();
    d = 32'h22;
    #1 chk("bp_wait_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_hold1", {32'd0, y2}, 64'h11);
    cyc();
    chk("bp_hold2", {32'd0, y2}, 64'h11);
    y_ready = 3'b100;
    #1 chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
    cyc();
    in_valid = 1'b0; y_ready = 3'b000;
    chk("bp_y2_new", {32'd0, y2}, 64'h22);
    chk("bp_valid", {61'd0, y_valid}, 64'b100);
    y_ready = 3'b111;
    cyc();
    y_ready = 3'b000;

    // Streaming into y0
    y_ready = 3'b001;
    for (int i = 1; i <= 8; i++) begin
      sel = 2'b00; d = 32'(i); in_valid = 1'b1;
      #1 chk("stream_ready", {63'd0, in_ready}, 64'd1);
      cyc();
      chk("stream_y0", {32'd0, y0}, 64'(i));
      chk("stream_valid0", {63'd0, y_valid[0]}, 64'd1);
    end
    in_valid = 1'b0;
    cyc();
    y_ready = 3'b000;

    // Invalid select
    sel = 2'b11; d = 32'hFFFF; in_valid = 1'b1;
    #1 chk("bad_ready", {63'd0, in_ready}, 64'd1);
    cyc();
    in_valid = 1'b0;
    chk("bad_err_hi", {63'd0, err}, 64'd1);
    chk("bad_valid", {61'd0, y_valid}, 64'd0);
    chk("bad_y0", {32'd0, y0}, 64'h8);
    chk("bad_y1", {32'd0, y1}, 64'hDEADBEEF);
    chk("bad_y2", {32'd0, y2}, 64'h22);
    cyc();
    chk("bad_err_lo", {63'd0, err}, 64'd0);

    // Reset mid-operation
    y_ready = 3'b000; in_valid = 1'b1;
    sel = 2'b00; d = 32'hA; cyc();
    sel = 2'b01; d = 32'hB; cyc();
    sel = 2'b10; d = 32'hC; cyc();
    in_valid = 1'b0;
    chk("mid_full", {61'd0, y_valid}, 64'b111);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {61'd0, y_valid}, 64'd0);
    chk("mid_rst_y0", {32'd0, y0}, 64'd0);
    chk("mid_rst_y1", {32'd0, y1}, 64'd0);
    chk("mid_rst_y2", {32'd0, y2}, 64'd0);
    chk("mid_rst_err", {63'd0, err}, 64'd0);
    #1 rst_n = 1'b1;
    cyc();

    // Randomized traffic checked by the model
    for (int n = 0; n < 3000; n++) begin
      sel      = 2'($urandom_range(0, 3));
      d        = $urandom;
      in_valid = 1'($urandom_range(0, 1));
      y_ready  = 3'($urandom_range(0, 7));
      cyc();
    end
    in_valid = 1'b0;
    y_ready  = 3'b111;
    cyc();

`ifdef DEMUX_1X3_STATS_EN
    // Counter wrap: 65537 drains on y0 after a fresh reset
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    cyc();
    y_ready = 3'b001; sel = 2'b00; in_valid = 1'b1;
    for (int n = 0; n < 65537; n++) begin
      d = 32'(n);
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    y_ready = 3'b000;
    chk("cnt0_wrap", {48'd0, cnt0}, 64'd1);
    chk("cnt1_idle", {48'd0, cnt1}, 64'd0);
    chk("cnt2_idle", {48'd0, cnt2}, 64'd0);
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_demux_1x3
`default_nettype wire

// File: doc/demux_1x3.md
DEMUX_1X3 -- requirements
Module: demux_1x3

Interface
REQ-001 The block SHALL have parameter bitwidth, default 32, giving the data width of the input and of each output.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port sel, input, 2 bits: destination select; 00 selects y0, 01 selects y1, 10 selects y2, 11 is invalid.
REQ-005 The block SHALL have port d, input, bitwidth bits: input data word.
REQ-006 The block SHALL have port in_valid, input, 1 bit: d and sel are valid this cycle.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts d this cycle.
REQ-008 The block SHALL have ports y0, y1 and y2, output, bitwidth bits each: registered output data.
REQ-009 The block SHALL have port y_valid, output, 3 bits: bit i means yi holds a valid word.
REQ-010 The block SHALL have port y_ready, input, 3 bits: bit i means the consumer of yi takes the word this cycle.
REQ-011 The block SHALL have port err, output, 1 bit: one-cycle pulse when a word with sel=11 is consumed.

Function
REQ-012 Each output SHALL own a one-entry slot with two states. EMPTY goes to FULL on a load. FULL goes to EMPTY on a drain without a load. FULL stays FULL on a simultaneous load and drain.
REQ-013 A transfer in SHALL occur when in_valid=1 and in_ready=1 at a rising clk edge.
REQ-014 For sel in {00,01,10}, in_ready SHALL equal (slot[sel] EMPTY) OR y_ready[sel], evaluated combinationally.
REQ-015 For sel=11, in_ready SHALL be 1. The word SHALL be discarded, no slot SHALL change, and err SHALL be 1 for exactly the following cycle.
REQ-016 Latency SHALL be one cycle: a word accepted at edge N appears on y[sel] with y_valid[sel]=1 after edge N.
REQ-017 A drain of output i SHALL occur when y_valid[i]=1 and y_ready[i]=1 at a rising edge.
REQ-018 Throughput SHALL be one word per cycle into the same output when its consumer holds y_ready high, with no bubble.
REQ-019 While y_valid[i]=1 and y_ready[i]=0, yi SHALL hold stable.
REQ-020 Drains on outputs other than the one being loaded SHALL proceed independently in the same cycle.
REQ-021 yi SHALL retain its last value after draining. Only y_valid[i] clears.
REQ-022 in_ready SHALL not depend on in_valid. Changing sel while in_valid=0 SHALL have no effect.

Reset
REQ-023 On rst_n=0, all of the following SHALL be 0 immediately, regardless of clk: y0, y1, y2, y_valid and err. All slots SHALL be EMPTY.
REQ-024 A reset asserted mid-operation SHALL discard all held words with no drain reported.
REQ-025 The first transfer SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-026 Macro DEMUX_1X3_STATS_EN SHALL control transfer counters.
REQ-027 With DEMUX_1X3_STATS_EN defined, the block SHALL add outputs cnt0, cnt1 and cnt2, 16 bits each.
REQ-028 Each cnti SHALL increment by 1 on each drain of output i, wrap from 0xFFFF to 0x0000, and reset to 0.
REQ-029 Without DEMUX_1X3_STATS_EN, those ports and their logic SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-030 Shared package demux_pkg SHALL hold:
- the select encodings SEL_Y0=2'b00, SEL_Y1=2'b01, SEL_Y2=2'b10 and SEL_BAD=2'b11;
- the default width constant 32;
- the slot state encodings EMPTY and FULL.
REQ-031 The slot logic SHALL be sub-module demux_slot, instantiated three times. Each instance holds the data register, the valid flag and the optional counter.

Verification
REQ-032 Reset then single word: after reset, apply sel=01, d=0xDEADBEEF and in_valid=1 for one cycle, with y_ready=111. Next cycle y1=0xDEADBEEF and y_valid=010. One cycle later y_valid=000.
REQ-033 Backpressure: y_ready=000; send 0x11 to y2 (accepted), then 0x22 to y2. Required response:
- in_ready=0 while the second word waits;
- y2 holds 0x11;
- raise y_ready[2] for one cycle: 0x22 is accepted that same cycle and y2=0x22 next cycle.
REQ-034 Streaming: send 0x1..0x8 to y0 back-to-back with y_ready[0]=1. Required response: in_ready stays 1, and y0 shows 0x1..0x8 on consecutive cycles.
REQ-035 Invalid select: send sel=11, d=0xFFFF. Required response:
- in_ready=1;
- err=1 for exactly one cycle;
- y_valid unchanged;
- no output data changes.
REQ-036 Reset mid-operation: fill all three slots with y_ready=000, then pulse rst_n low between edges. Required response: y_valid=000 and all outputs 0 immediately, with no clk edge needed.
REQ-037 With DEMUX_1X3_STATS_EN defined: perform 65537 drains on y0. Required response: cnt0=1; cnt1 and cnt2 unchanged.
